ir_fetch_queue: RTL and testbench
=================================

Name: ir_fetch_queue

Overview:
Parametrised instruction register for the multicycle RISC-V core: a DEPTH-entry FIFO of fetched instruction words with their PCs.
- Fetch side writes under a valid/ready handshake.
- Control/decode side consumes the head entry.
- Head entry is always presented pre-split into fields, with a sign-extended immediate selected by instruction format.
- Flush input discards queued words on branch/jump redirect.

Parameters:
XLEN, 32, width of out_pc, in_pc and imm.
DEPTH, 4, number of queue entries; power of two, >= 2.
CNT_W, $clog2(DEPTH+1), width of count.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
flush  input  1  synchronous discard of all entries
in_valid  input  1  fetch word available
in_ready  output  1  queue can accept a word this cycle
in_instr  input  32  fetched instruction word
in_pc  input  XLEN  PC of in_instr
out_valid  output  1  head entry valid
out_ready  input  1  consumer takes head this cycle (replaces IRWr)
out_instr  output  32  head instruction word
out_pc  output  XLEN  head PC
op  output  7  out_instr[6:0]
rd  output  5  out_instr[11:7]
funct3  output  3  out_instr[14:12]
rs1  output  5  out_instr[19:15]
rs2  output  5  out_instr[24:20]
funct7  output  7  out_instr[31:25]
imm  output  XLEN  sign-extended immediate for head format
imm_fmt  output  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J
count  output  CNT_W  occupied entries

Behaviour:
- Reset (async, rst=1):
  - Read/write pointers and count go to 0.
  - out_valid=0, in_ready=1.
  - Storage array is not reset.
- Push: in_valid && in_ready at posedge writes {in_instr, in_pc} at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
- Pop: out_valid && out_ready at posedge increments rd_ptr, wrapping modulo DEPTH.
- Push and pop in the same cycle: both happen and count is unchanged.
- in_ready = (count != DEPTH). This is a registered-state function only.
  - No same-cycle pass-through when full: a pop while full does not raise in_ready that cycle.
- out_valid = (count != 0).
- Latency: a word pushed into an empty queue appears on the out_* ports in the next cycle, with out_valid=1.
- Head outputs (out_instr, out_pc, fields, imm, imm_fmt) are decoded combinationally from the head entry's registered storage. They are stable while no pop occurs.
- Empty queue: out_instr is forced to 32'h00000013 (NOP) and out_pc to 0, with fields and imm decoded from that NOP.
  - Result: op=7'h13, imm_fmt=1, imm=0.
- Flush: synchronous and has highest priority. At the posedge it sets pointers and count to 0. A push or pop in the same cycle is ignored.
- Behaviour with rst asserted mid-operation: all entries are lost immediately, without waiting for a clock edge.
- imm_fmt is decoded from op:
  - 0010011, 0000011, 1100111, 1110011 -> I; imm = sext(instr[31:20]).
  - 0100011 -> S; imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 -> B; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111, 0010111 -> U; imm = {instr[31:12], 12'b0}, sign-extended to XLEN.
  - 1101111 -> J; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Any other op -> fmt 0, imm = 0.
- Sign extension is taken from instr[31] in all cases.
- Overflow and underflow are impossible by construction.
  - Push attempts while in_ready=0 are dropped with no state change.
  - Pop attempts while out_valid=0 are ignored.

Test Plan:
- Reset then idle: check count=0, out_valid=0, in_ready=1, out_instr=32'h00000013, imm_fmt=1, imm=0.
- Push 32'h00500093 (addi x1,x0,5) at pc 0x100: next cycle out_valid=1, out_pc=0x100, rd=1, rs1=0, imm_fmt=1, imm=5.
- Push four words with DEPTH=4:
  - count=4 and in_ready=0.
  - A fifth push is dropped.
  - Popping four gives the original order and PCs.
  - count=0 afterwards and pointers have wrapped.
- Full queue with simultaneous in_valid and out_ready:
  - Only the pop occurs and count=3.
  - Next cycle, push and pop together keep count=3.
- Immediate decode:
  - 32'hFE112E23 (sw x1,-4(x2)) -> fmt 2, imm=32'hFFFFFFFC.
  - 32'hFE000EE3 (beq, -4) -> fmt 3, imm=32'hFFFFFFFC.
  - 32'h123450B7 (lui) -> fmt 4, imm=32'h12345000.
  - 32'hFFDFF0EF (jal -4) -> fmt 5, imm=32'hFFFFFFFC.
  - 32'h00208033 (add) -> fmt 0, imm=0.
- Flush with count=3 and in_valid=1 in the same cycle: next cycle count=0, out_valid=0. A mid-cycle rst pulse between clock edges empties the queue immediately.

Source files
------------

// File: rtl/ir_fetch_queue.sv
// Instruction register queue for the multicycle core: a DEPTH-entry FIFO of fetched
// instruction words and their PCs. The head entry is decoded combinationally into
// register fields and a sign-extended immediate so the control/decode side never
// waits on a separate decode stage.
module ir_fetch_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,

  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_instr_i,
  input  logic [XLEN-1:0]  in_pc_i,

  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_instr_o,
  output logic [XLEN-1:0]  out_pc_o,

  output logic [6:0]       op_o,
  output logic [4:0]       rd_o,
  output logic [2:0]       funct3_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o,
  output logic [6:0]       funct7_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       imm_fmt_o,

  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  // Presented on the head outputs whenever the queue is empty (addi x0,x0,0).
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  // Immediate format codes seen on imm_fmt_o.
  localparam logic [2:0] FmtNone = 3'd0;
  localparam logic [2:0] FmtI    = 3'd1;
  localparam logic [2:0] FmtS    = 3'd2;
  localparam logic [2:0] FmtB    = 3'd3;
  localparam logic [2:0] FmtU    = 3'd4;
  localparam logic [2:0] FmtJ    = 3'd5;

  // Major opcodes that select an immediate format.
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // Storage is deliberately left without reset; validity is tracked by count_q.
  logic [31:0]      instr_q [DEPTH];
  logic [XLEN-1:0]  pc_q    [DEPTH];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic             push;
  logic             pop;

  logic [31:0]      head_instr;
  logic signed [31:0] imm32;
  logic [2:0]       imm_fmt;

  // Handshake status depends on registered occupancy only, so a pop while full
  // does not open in_ready in the same cycle.
  assign in_ready_o  = (count_q != CNT_W'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign count_o     = count_q;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  // Next-state for pointers and occupancy; flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; async reset empties the queue immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write on an accepted push (a flush in the same cycle drops it).
  always_ff @(posedge clk) begin
    if (push && !flush_i) begin
      instr_q[wr_ptr_q] <= in_instr_i;
      pc_q[wr_ptr_q]    <= in_pc_i;
    end
  end

  // Head selection: substitute a NOP at PC 0 when nothing is queued.
  always_comb begin
    head_instr = NopInstr;
    out_pc_o   = '0;
    if (out_valid_o) begin
      head_instr = instr_q[rd_ptr_q];
      out_pc_o   = pc_q[rd_ptr_q];
    end
  end

  assign out_instr_o = head_instr;
  assign op_o        = head_instr[6:0];
  assign rd_o        = head_instr[11:7];
  assign funct3_o    = head_instr[14:12];
  assign rs1_o       = head_instr[19:15];
  assign rs2_o       = head_instr[24:20];
  assign funct7_o    = head_instr[31:25];

  // Immediate format and value; instr[31] is the sign bit for every format.
  always_comb begin
    imm_fmt = FmtNone;
    imm32   = '0;
    case (head_instr[6:0])
      OpImm, OpLoad, OpJalr, OpSystem: begin
        imm_fmt = FmtI;
        imm32   = {{20{head_instr[31]}}, head_instr[31:20]};
      end
      OpStore: begin
        imm_fmt = FmtS;
        imm32   = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
      end
      OpBranch: begin
        imm_fmt = FmtB;
        imm32   = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                   head_instr[30:25], head_instr[11:8], 1'b0};
      end
      OpLui, OpAuipc: begin
        imm_fmt = FmtU;
        imm32   = {head_instr[31:12], 12'b0};
      end
      OpJal: begin
        imm_fmt = FmtJ;
        imm32   = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                   head_instr[20], head_instr[30:21], 1'b0};
      end
      default: begin
        imm_fmt = FmtNone;
        imm32   = '0;
      end
    endcase
  end

  // Size cast of the signed value sign-extends to XLEN.
  assign imm_o     = XLEN'(imm32);
  assign imm_fmt_o = imm_fmt;

endmodule

// File: tb/tb_ir_fetch_queue.sv
// Self-checking bench for ir_fetch_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_ir_fetch_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [XLEN-1:0]  out_pc;
  logic [6:0]       op;
  logic [4:0]       rd;
  logic [2:0]       funct3;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [6:0]       funct7;
  logic [XLEN-1:0]  imm;
  logic [2:0]       imm_fmt;
  logic [CNT_W-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: in-order queue of (instr, pc) pairs.
  logic [31:0] q_instr[$];
  logic [31:0] q_pc[$];

  always #5 clk = ~clk;

  ir_fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_instr_i  (in_instr),
    .in_pc_i     (in_pc),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_instr_o (out_instr),
    .out_pc_o    (out_pc),
    .op_o        (op),
    .rd_o        (rd),
    .funct3_o    (funct3),
    .rs1_o       (rs1),
    .rs2_o       (rs2),
    .funct7_o    (funct7),
    .imm_o       (imm),
    .imm_fmt_o   (imm_fmt),
    .count_o     (count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Immediate reference computed arithmetically from field values.
  function automatic void ref_decode(input logic [31:0] ins, output int unsigned fmt,
                                     output logic [31:0] val);
    longint v;
    v   = 0;
    fmt = 0;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        fmt = 1;
        v = longint'(ins[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'b0100011: begin
        fmt = 2;
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'b1100011: begin
        fmt = 3;
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
          + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'b0110111, 7'b0010111: begin
        fmt = 4;
        v = longint'(ins) - longint'(ins % 4096);
      end
      7'b1101111: begin
        fmt = 5;
        v = longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * (1 << 12)
          + longint'(ins[20]) * (1 << 11) + longint'(ins[30:21]) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      default: begin
        fmt = 0;
        v = 0;
      end
    endcase
    val = 32'(v);
  endfunction

  task automatic check_all();
    logic [31:0] hi;
    logic [31:0] hp;
    logic [31:0] ev;
    int unsigned ef;
    int unsigned sz;
    sz = q_instr.size();
    hi = 32'h0000_0013;
    hp = '0;
    if (sz != 0) begin
      hi = q_instr[0];
      hp = q_pc[0];
    end
    ref_decode(hi, ef, ev);
    check_eq("count", count, sz);
    check_eq("out_valid", out_valid, sz != 0);
    check_eq("in_ready", in_ready, sz != DEPTH);
    check_eq("out_instr", out_instr, hi);
    check_eq("out_pc", out_pc, hp);
    check_eq("op", op, hi[6:0]);
    check_eq("rd", rd, hi[11:7]);
    check_eq("funct3", funct3, hi[14:12]);
    check_eq("rs1", rs1, hi[19:15]);
    check_eq("rs2", rs2, hi[24:20]);
    check_eq("funct7", funct7, hi[31:25]);
    check_eq("imm", imm, ev);
    check_eq("imm_fmt", imm_fmt, ef);
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    bit can_push;
    bit can_pop;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    can_push = q_instr.size() != DEPTH;
    can_pop  = q_instr.size() != 0;
    if (fl) begin
      q_instr.delete();
      q_pc.delete();
    end else begin
      if (rdy && can_pop) begin
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end
      if (v && can_push) begin
        q_instr.push_back(ins);
        q_pc.push_back(pc);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    check_all();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] r;
    ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};
    r = $urandom();
    r[6:0] = ops[$urandom_range(9, 0)];
    return r;
  endfunction

  logic [31:0] words [4];
  logic [31:0] dec_ins [5];
  logic [31:0] dec_imm [5];
  logic [2:0]  dec_fmt [5];

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    words   = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'hFFC10213};
    dec_ins = '{32'hFE112E23, 32'hFE000EE3, 32'h123450B7, 32'hFFDFF0EF, 32'h00208033};
    dec_imm = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFFC, 32'h00000000};
    dec_fmt = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset then idle.
    check_eq("rst_count", count, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_nop", out_instr, 32'h00000013);
    check_eq("rst_fmt", imm_fmt, 1);
    check_eq("rst_imm", imm, 0);
    check_all();

    // Single push into an empty queue appears next cycle.
    step(1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0);
    check_eq("addi_valid", out_valid, 1);
    check_eq("addi_pc", out_pc, 32'h100);
    check_eq("addi_rd", rd, 1);
    check_eq("addi_rs1", rs1, 0);
    check_eq("addi_fmt", imm_fmt, 1);
    check_eq("addi_imm", imm, 5);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Fill, overfill, drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, words[i], 32'h200 + 32'(4 * i), 1'b0, 1'b0);
    check_eq("full_count", count, 4);
    check_eq("full_in_ready", in_ready, 0);
    step(1'b1, 32'hDEADBEEF, 32'h999, 1'b0, 1'b0);
    check_eq("drop_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_instr", out_instr, words[i]);
      check_eq("drain_pc", out_pc, 32'h200 + 32'(4 * i));
      step(1'b0, '0, '0, 1'b1, 1'b0);
    end
    check_eq("drained_count", count, 0);

    // Full with simultaneous push and pop: only the pop happens.
    for (int i = 0; i < 4; i++) step(1'b1, words[i], 32'h300 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b1, 32'h00100013, 32'h400, 1'b1, 1'b0);
    check_eq("full_pp_count", count, 3);
    step(1'b1, 32'h00200013, 32'h404, 1'b1, 1'b0);
    check_eq("pp_count", count, 3);
    check_eq("pp_head", out_instr, words[2]);

    // Flush beats a same-cycle push.
    step(1'b1, 32'h00300013, 32'h408, 1'b1, 1'b1);
    check_eq("flush_count", count, 0);
    check_eq("flush_valid", out_valid, 0);

    // Immediate decode of each format.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, dec_ins[i], 32'h500 + 32'(4 * i), 1'b0, 1'b0);
      check_eq("dec_fmt", imm_fmt, dec_fmt[i]);
      check_eq("dec_imm", imm, dec_imm[i]);
      step(1'b0, '0, '0, 1'b1, 1'b0);
    end

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(1, 0)), rand_instr(), $urandom(),
           1'($urandom_range(1, 0)), $urandom_range(19, 0) == 0);
    end

    // Asynchronous reset between clock edges empties the queue at once.
    step(1'b1, 32'h00100093, 32'h600, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 32'h604, 1'b0, 1'b0);
    step(1'b1, 32'h00300093, 32'h608, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check_eq("async_rst_count", count, 0);
    check_eq("async_rst_valid", out_valid, 0);
    rst = 1'b0;
    q_instr.delete();
    q_pc.delete();
    @(negedge clk);
    check_all();
    step(1'b1, 32'h00700093, 32'h700, 1'b0, 1'b0);
    check_eq("post_rst_pc", out_pc, 32'h700);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
